// File: rtl/lighthouse_pkg.sv
// Shared constants, types and the sync-pulse width classifier for the lighthouse v1 pulse decoder.
package lighthouse_pkg;

  localparam int TICK_W  = 20;
  localparam int WIDTH_W = 13;

  localparam int GLITCH_MIN_DEF    = 25;
  localparam int SWEEP_MAX_DEF     = 2500;
  localparam int SYNC_MAX_DEF      = 7030;
  localparam int PAIR_GAP_DEF      = 30000;
  localparam int SWEEP_TIMEOUT_DEF = 420000;

  localparam logic [WIDTH_W-1:0] WIDTH_SAT = '1;

  // Sync width bounds; a sync's class is how many of these its width reaches.
  localparam int NUM_BOUNDS = 7;
  localparam logic [NUM_BOUNDS-1:0][WIDTH_W-1:0] CLASS_BOUNDS = {
    13'd6510, 13'd5990, 13'd5469, 13'd4948, 13'd4427, 13'd3906, 13'd3385
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } lh_state_e;

  typedef struct packed {
    logic [4:0]        sensor_id;
    logic              lh;
    logic              axis;
    logic              data;
    logic [3:0]        rsvd;
    logic [TICK_W-1:0] sweep;
  } report_t;

  function automatic logic [2:0] sync_class(input logic [WIDTH_W-1:0] width);
    logic [2:0] cls;
    cls = '0;
    for (int i = 0; i < NUM_BOUNDS; i++) begin
      if (width >= CLASS_BOUNDS[i]) cls = cls + 3'd1;
    end
    return cls;
  endfunction

endpackage

// File: rtl/lighthouse_pulse_timer.sv
// Synchronises the envelope line, detects light edges and measures each pulse's rise time and width.
module lighthouse_pulse_timer
  import lighthouse_pkg::*;
#(
  parameter bit E_ACTIVE_HIGH = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               e_i,
  output logic               fall_o,
  output logic [WIDTH_W-1:0] width_o,
  output logic [TICK_W-1:0]  t_rise_o,
  output logic [TICK_W-1:0]  now_o
);

  logic [1:0]         sync_q, sync_d;
  logic               light_q, light_d;
  logic               pulse_active_q, pulse_active_d;
  logic [TICK_W-1:0]  now_q, now_d;
  logic [TICK_W-1:0]  t_rise_q, t_rise_d;
  logic [WIDTH_W-1:0] width_q, width_d;

  logic light_raw;
  logic light;
  logic rise;
  logic fall;

  always_comb begin
    light_raw = E_ACTIVE_HIGH ? e_i : ~e_i;
    sync_d    = {sync_q[0], light_raw};
    light     = sync_q[1];
    light_d   = light;
    rise      = light & ~light_q;
    fall      = ~light & light_q;
    now_d     = now_q + 1'b1;

    pulse_active_d = pulse_active_q;
    t_rise_d       = t_rise_q;
    width_d        = width_q;

    // The rise cycle itself counts as the first lit tick, so width equals lit cycles at the fall.
    if (!enable) begin
      pulse_active_d = 1'b0;
    end else if (rise) begin
      pulse_active_d = 1'b1;
      t_rise_d       = now_q;
      width_d        = {{(WIDTH_W-1){1'b0}}, 1'b1};
    end else if (fall) begin
      pulse_active_d = 1'b0;
    end else if (light && pulse_active_q && (width_q != WIDTH_SAT)) begin
      width_d = width_q + 1'b1;
    end
  end

  // Reset treats the line as lit so a pulse already in progress never produces a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= 2'b11;
      light_q        <= 1'b1;
      pulse_active_q <= 1'b0;
      now_q          <= '0;
      t_rise_q       <= '0;
      width_q        <= '0;
    end else begin
      sync_q         <= sync_d;
      light_q        <= light_d;
      pulse_active_q <= pulse_active_d;
      now_q          <= now_d;
      t_rise_q       <= t_rise_d;
      width_q        <= width_d;
    end
  end

  assign fall_o   = fall & pulse_active_q & enable;
  assign width_o  = width_q;
  assign t_rise_o = t_rise_q;
  assign now_o    = now_q;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Per-sensor lighthouse decoder: classifies pulses, arms on sync, reports the first sweep centre
// over a single-entry valid/ready register with a saturating drop counter.
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int SENSOR_ID     = 0,
  parameter bit E_ACTIVE_HIGH = 1'b0,
  parameter int GLITCH_MIN    = GLITCH_MIN_DEF,
  parameter int SWEEP_MAX     = SWEEP_MAX_DEF,
  parameter int SYNC_MAX      = SYNC_MAX_DEF,
  parameter int PAIR_GAP      = PAIR_GAP_DEF,
  parameter int SWEEP_TIMEOUT = SWEEP_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        e_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  overflow_cnt_o
);

  localparam logic [WIDTH_W-1:0] GLITCH_T  = WIDTH_W'(GLITCH_MIN);
  localparam logic [WIDTH_W-1:0] SWEEP_T   = WIDTH_W'(SWEEP_MAX);
  localparam logic [WIDTH_W-1:0] SYNC_T    = WIDTH_W'(SYNC_MAX);
  localparam logic [TICK_W-1:0]  PAIR_T    = TICK_W'(PAIR_GAP);
  localparam logic [TICK_W-1:0]  TIMEOUT_T = TICK_W'(SWEEP_TIMEOUT);
  localparam logic [4:0]         ID_T      = 5'(SENSOR_ID);

  logic               fall;
  logic [WIDTH_W-1:0] width;
  logic [TICK_W-1:0]  t_rise;
  logic [TICK_W-1:0]  now;

  lighthouse_pulse_timer #(
    .E_ACTIVE_HIGH (E_ACTIVE_HIGH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .e_i      (e_i),
    .fall_o   (fall),
    .width_o  (width),
    .t_rise_o (t_rise),
    .now_o    (now)
  );

  lh_state_e         state_q, state_d;
  logic [TICK_W-1:0] ref_q, ref_d;
  logic [TICK_W-1:0] last_sync_q, last_sync_d;
  logic              lh_q, lh_d;
  logic              axis_q, axis_d;
  logic              data_q, data_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        ovf_q, ovf_d;

  logic       in_range;
  logic       is_sweep;
  logic       is_sync;
  logic [2:0] cls;
  logic       pair;
  logic       timed_out;
  logic       report_fire;
  report_t    report;

  always_comb begin
    in_range  = (width >= GLITCH_T) && (width < SYNC_T);
    is_sweep  = in_range && (width < SWEEP_T);
    is_sync   = in_range && !is_sweep;
    cls       = sync_class(width);
    pair      = (t_rise - last_sync_q) < PAIR_T;
    timed_out = (now - ref_q) >= TIMEOUT_T;

    report.sensor_id = ID_T;
    report.lh        = lh_q;
    report.axis      = axis_q;
    report.data      = data_q;
    report.rsvd      = '0;
    report.sweep     = (t_rise - ref_q) + {{(TICK_W-WIDTH_W+1){1'b0}}, width[WIDTH_W-1:1]};

    state_d     = state_q;
    ref_d       = ref_q;
    last_sync_d = last_sync_q;
    lh_d        = lh_q;
    axis_d      = axis_q;
    data_d      = data_q;
    report_fire = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      if ((state_q == ST_ARMED) && timed_out) state_d = ST_IDLE;
      if (fall && is_sync) begin
        last_sync_d = t_rise;
        if (!cls[2]) begin
          ref_d   = t_rise;
          lh_d    = pair;
          axis_d  = cls[0];
          data_d  = cls[1];
          state_d = ST_ARMED;
        end
      end else if (fall && is_sweep && (state_q == ST_ARMED) && !timed_out) begin
        report_fire = 1'b1;
        state_d     = ST_IDLE;
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    if (out_valid_q && ready_i) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
    // A handshake in the same cycle still counts as full: the new report is not bypassed.
    if (report_fire) begin
      if (out_valid_q) begin
        if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = report;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ref_q       <= '0;
      last_sync_q <= '0;
      lh_q        <= 1'b0;
      axis_q      <= 1'b0;
      data_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      last_sync_q <= last_sync_d;
      lh_q        <= lh_d;
      axis_q      <= axis_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign data_o         = out_data_q;
  assign valid_o        = out_valid_q;
  assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Directed bench for lighthouse_pulse_decoder; pair gap and sweep timeout are scaled down to keep runtime short.
module tb_lighthouse_pulse_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        e_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  overflow_cnt_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] words[$];

  lighthouse_pulse_decoder #(
    .SENSOR_ID     (3),
    .E_ACTIVE_HIGH (1'b0),
    .PAIR_GAP      (6000),
    .SWEEP_TIMEOUT (12000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .e_i            (e_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .overflow_cnt_o (overflow_cnt_o)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && valid_o && ready_i) begin
      words.push_back(data_o);
      $display("word %08h accepted at %0t", data_o, $time);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // e_i is active-low: light for w clock edges.
  task automatic pulse(input int w);
    e_i = 1'b0;
    tick(w);
    e_i = 1'b1;
  endtask

  function automatic logic [31:0] word_at(input int i);
    logic [31:0] none;
    none = 32'hDEAD_BEEF;
    return (i < words.size()) ? words[i] : none;
  endfunction

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    e_i     = 1'b1;
    ready_i = 1'b1;
    tick(3);
    check_val("rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("rst_data", data_o, 32'd0);
    check_val("rst_ovf", {24'd0, overflow_cnt_o}, 32'd0);
    reset = 1'b0;
    tick(6500);

    // 1: plain sync then sweep 4000 ticks later, width 500
    words.delete();
    pulse(3125); tick(875); pulse(500); tick(1600);
    check_val("t1_count", words.size(), 32'd1);
    check_val("t1_word", word_at(0), 32'h1800_109A);

    // 2: skip sync, then paired sync class 1 -> lh=1 axis=1
    words.delete();
    pulse(5208); tick(292); pulse(3646); tick(1354); pulse(200); tick(900);
    check_val("t2_count", words.size(), 32'd1);
    check_val("t2_word", word_at(0), 32'h1E00_13EC);

    // 3a: width 3384 is class 0; glitch and over-long pulse ignored while armed
    words.delete();
    pulse(3384); tick(100); pulse(10); tick(100); pulse(7500); tick(100); pulse(400); tick(100);
    check_val("t3a_count", words.size(), 32'd1);
    check_val("t3a_word", word_at(0), 32'h1800_2C82);

    // 3b: width 3385 is class 1
    words.delete();
    pulse(3385); tick(1000); pulse(300); tick(1400);
    check_val("t3b_count", words.size(), 32'd1);
    check_val("t3b_word", word_at(0), 32'h1A00_11B7);

    // 4: backpressure, second report dropped
    words.delete();
    ready_i = 1'b0;
    pulse(3125); tick(1000); pulse(100); tick(1800);
    pulse(3125); tick(1000); pulse(100); tick(50);
    check_val("t4_held_valid", {31'd0, valid_o}, 32'd1);
    check_val("t4_held_data", data_o, 32'h1800_104F);
    check_val("t4_ovf", {24'd0, overflow_cnt_o}, 32'd1);
    ready_i = 1'b1;
    tick(5);
    check_val("t4_count", words.size(), 32'd1);
    check_val("t4_word", word_at(0), 32'h1800_104F);
    check_val("t4_valid_after", {31'd0, valid_o}, 32'd0);
    tick(1800);

    // 5: sweep after timeout is not reported
    words.delete();
    pulse(3125); tick(9375); pulse(200); tick(50);
    check_val("t5_count", words.size(), 32'd0);
    check_val("t5_ovf", {24'd0, overflow_cnt_o}, 32'd1);

    // 6: reset mid-pulse with a held word
    words.delete();
    ready_i = 1'b0;
    pulse(3125); tick(1000); pulse(100); tick(10);
    check_val("t6_held_valid", {31'd0, valid_o}, 32'd1);
    e_i = 1'b0;
    tick(200);
    reset = 1'b1;
    #1;
    check_val("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("t6_rst_ovf", {24'd0, overflow_cnt_o}, 32'd0);
    check_val("t6_rst_data", data_o, 32'd0);
    tick(5);
    reset = 1'b0;
    tick(100);
    e_i = 1'b1;
    ready_i = 1'b1;
    tick(20);
    check_val("t6_partial", words.size(), 32'd0);
    pulse(300); tick(50);
    check_val("t6_idle_sweep", words.size(), 32'd0);
    pulse(5208); tick(300); pulse(300); tick(50);
    check_val("t6_skip_sweep", words.size(), 32'd0);
    pulse(3646); tick(1000); pulse(300); tick(50);
    check_val("t6_count", words.size(), 32'd1);
    check_val("t6_word", word_at(0), 32'h1E00_12BC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
